// File: rtl/miriscv_data_bus.sv
// Data-bus interconnect: decodes one core request at a time onto N_SLAVES
// address windows, waits for the selected slave's ready and records bus faults.
module miriscv_data_bus #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {N_SLAVES{32'hFFFF_FF00}},
    parameter int TIMEOUT = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       m_req_i,
    input  logic                       m_we_i,
    input  logic [BE_W-1:0]            m_be_i,
    input  logic [ADDR_W-1:0]          m_addr_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    output logic                       m_gnt_o,
    output logic                       m_rvalid_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic                       m_err_o,
    output logic [N_SLAVES-1:0]        s_req_o,
    output logic                       s_we_o,
    output logic [BE_W-1:0]            s_be_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
    input  logic [N_SLAVES-1:0]        s_ready_i,
    output logic [ADDR_W-1:0]          err_addr_o,
    output logic                       err_we_o,
    output logic [ERR_CNT_W-1:0]       err_cnt_o,
    input  logic                       err_clr_i,
    output logic [1:0]                 dbg_state_o
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, ERROR = 2'd3} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   saddr_q, saddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                rvalid_q, rvalid_d;
    logic                rerr_q, rerr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                err_we_q, err_we_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic [ADDR_W-1:0]   hit_base;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                fault;
    logic [ADDR_W-1:0]   fault_addr;
    logic                fault_we;

    // Scan from the top index down so the lowest hitting window wins on overlap.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((m_addr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
                (SLAVE_BASE[k*ADDR_W +: ADDR_W] & SLAVE_MASK[k*ADDR_W +: ADDR_W])) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(k);
                hit_base = SLAVE_BASE[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_req_o   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ready  = s_ready_i[k];
                sel_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
                s_req_o[k] = (state_q == ACCESS);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        saddr_d    = saddr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        to_cnt_d   = to_cnt_q;
        rdata_d    = '0;
        fault      = 1'b0;
        fault_addr = addr_q;
        fault_we   = we_q;
        m_gnt_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    m_gnt_o    = 1'b1;
                    we_d       = m_we_i;
                    be_d       = m_be_i;
                    addr_d     = m_addr_i;
                    wdata_d    = m_wdata_i;
                    to_cnt_d   = '0;
                    fault_addr = m_addr_i;
                    fault_we   = m_we_i;
                    if (hit) begin
                        sel_d   = hit_idx;
                        saddr_d = m_addr_i - hit_base;
                        state_d = ACCESS;
                    end else begin
                        saddr_d = '0;
                        fault   = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            ACCESS: begin
                // Ready is tested first so a last-cycle completion is not a timeout.
                if (sel_ready) begin
                    rdata_d  = we_q ? '0 : sel_rdata;
                    to_cnt_d = '0;
                    state_d  = RESP;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = '0;
                    fault    = 1'b1;
                    state_d  = ERROR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rvalid_d = (state_d == RESP) || (state_d == ERROR);
        rerr_d   = (state_d == ERROR);

        err_addr_d = err_addr_q;
        err_we_d   = err_we_q;
        err_cnt_d  = err_cnt_q;
        if (fault) begin
            err_addr_d = fault_addr;
            err_we_d   = fault_we;
            err_cnt_d  = err_clr_i ? ERR_CNT_W'(1) : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1);
        end else if (err_clr_i) begin
            err_addr_d = '0;
            err_we_d   = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            saddr_q    <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            to_cnt_q   <= '0;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            err_we_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            saddr_q    <= saddr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            to_cnt_q   <= to_cnt_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            err_we_q   <= err_we_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_rvalid_o  = rvalid_q;
    assign m_err_o     = rerr_q;
    assign m_rdata_o   = rdata_q;
    assign s_we_o      = we_q;
    assign s_be_o      = be_q;
    assign s_addr_o    = saddr_q;
    assign s_wdata_o   = wdata_q;
    assign err_addr_o  = err_addr_q;
    assign err_we_o    = err_we_q;
    assign err_cnt_o   = err_cnt_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_miriscv_data_bus.sv
// Directed bench for miriscv_data_bus: two slaves (0x000/256B, 0x1000/4KB),
// TIMEOUT=4, table of transactions plus reset, clear and saturation sequences.
module tb_miriscv_data_bus;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_req_i, m_we_i;
    logic [3:0]  m_be_i;
    logic [31:0] m_addr_i, m_wdata_i;
    logic        m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0] m_rdata_o;
    logic [1:0]  s_req_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [63:0] s_rdata_i;
    logic [1:0]  s_ready_i;
    logic [31:0] err_addr_o;
    logic        err_we_o;
    logic [7:0]  err_cnt_o;
    logic        err_clr_i;
    logic [1:0]  dbg_state_o;

    always #5 clk_i = ~clk_i;

    miriscv_data_bus #(
        .N_SLAVES(2), .ADDR_W(32), .DATA_W(32),
        .SLAVE_BASE({32'h0000_1000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_FF00}),
        .TIMEOUT(4), .ERR_CNT_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
        .err_addr_o(err_addr_o), .err_we_o(err_we_o), .err_cnt_o(err_cnt_o),
        .err_clr_i(err_clr_i), .dbg_state_o(dbg_state_o)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ready_cyc;   // cycle after grant on which ready is driven, 0 = never
        logic        noise;       // drive ready on the unselected slave throughout
        logic        clr;         // err_clr_i asserted in the grant cycle
        logic [31:0] rd0, rd1;
        logic [1:0]  exp_sreq;
        logic [31:0] exp_saddr;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_eaddr;
        logic        exp_ewe;
        logic [7:0]  exp_ecnt;
    } vec_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t vecs[9];

    function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input int rc, input logic noise,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic [1:0] sreq, input logic [31:0] saddr, input int lat,
                                input logic err, input logic [31:0] rdata,
                                input logic [31:0] eaddr, input logic ewe, input logic [7:0] ecnt);
        vec_t v;
        v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.ready_cyc = rc;
        v.noise = noise; v.clr = 1'b0; v.rd0 = rd0; v.rd1 = rd1; v.exp_sreq = sreq;
        v.exp_saddr = saddr; v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rdata;
        v.exp_eaddr = eaddr; v.exp_ewe = ewe; v.exp_ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        bit done;
        @(negedge clk_i);
        m_req_i = 1'b1; m_we_i = v.we; m_be_i = v.be; m_addr_i = v.addr; m_wdata_i = v.wdata;
        err_clr_i = v.clr; s_rdata_i = {v.rd1, v.rd0}; s_ready_i = 2'b00;
        #1 chk({tag, " gnt"}, 32'(m_gnt_o), 32'd1);
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            err_clr_i = 1'b0;
            if (m_rvalid_o) begin
                done = 1'b1;
                m_req_i = 1'b0; s_ready_i = 2'b00;
                chk({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
                chk({tag, " err"}, 32'(m_err_o), 32'(v.exp_err));
                chk({tag, " rdata"}, m_rdata_o, v.exp_rdata);
                chk({tag, " err_addr"}, err_addr_o, v.exp_eaddr);
                chk({tag, " err_we"}, 32'(err_we_o), 32'(v.exp_ewe));
                chk({tag, " err_cnt"}, 32'(err_cnt_o), 32'(v.exp_ecnt));
            end else begin
                chk({tag, " s_req"}, 32'(s_req_o), 32'(v.exp_sreq));
                chk({tag, " s_addr"}, s_addr_o, v.exp_saddr);
                chk({tag, " s_wdata"}, s_wdata_o, v.wdata);
                chk({tag, " s_be"}, 32'(s_be_o), 32'(v.be));
                chk({tag, " s_we"}, 32'(s_we_o), 32'(v.we));
                chk({tag, " gnt busy"}, 32'(m_gnt_o), 32'd0);
                // Core keeps requesting with scrambled fields; the latches must not move.
                m_we_i = ~v.we; m_be_i = ~v.be; m_addr_i = ~v.addr; m_wdata_i = ~v.wdata;
                s_ready_i = ((cyc == v.ready_cyc) ? v.exp_sreq : 2'b00) |
                            (v.noise ? ~v.exp_sreq : 2'b00);
            end
        end
        if (!done) begin
            m_req_i = 1'b0; s_ready_i = 2'b00;
            chk({tag, " rvalid seen"}, 32'(done), 32'd1);
        end
        @(negedge clk_i);
        chk({tag, " rvalid pulse"}, 32'(m_rvalid_o), 32'd0);
        chk({tag, " err idle"}, 32'(m_err_o), 32'd0);
        chk({tag, " rdata idle"}, m_rdata_o, 32'd0);
    endtask

    initial begin
        vec_t v;
        bit   saw;
        //             we  be    addr          wdata         rc n  rd0           rd1           sreq   saddr     lat err rdata         eaddr        ewe ecnt
        vecs[0] = mk(0, 4'hF, 32'h0000_0040, 32'h0,        1, 0, 32'hDEADBEEF, 32'hCAFEF00D, 2'b01, 32'h40, 2, 0, 32'hDEADBEEF, 32'h0,       0, 8'd0);
        vecs[1] = mk(1, 4'h3, 32'h0000_1008, 32'h12345678, 4, 0, 32'h0,        32'hAAAA5555, 2'b10, 32'h08, 5, 0, 32'h0,        32'h0,       0, 8'd0);
        vecs[2] = mk(0, 4'hF, 32'h0000_2000, 32'h0,        0, 0, 32'h1,        32'h2,        2'b00, 32'h0,  1, 1, 32'h0,        32'h2000,    0, 8'd1);
        vecs[3] = mk(0, 4'hF, 32'h0000_1000, 32'h0,        0, 1, 32'h77777777, 32'hFFFFFFFF, 2'b10, 32'h0,  5, 1, 32'h0,        32'h1000,    0, 8'd2);
        vecs[4] = mk(0, 4'hF, 32'h0000_10FF, 32'h0,        2, 0, 32'h55555555, 32'h0BADF00D, 2'b10, 32'hFF, 3, 0, 32'h0BADF00D, 32'h1000,    0, 8'd2);
        vecs[5] = mk(0, 4'hC, 32'h0000_00FC, 32'h0,        3, 1, 32'h11223344, 32'h99999999, 2'b01, 32'hFC, 4, 0, 32'h11223344, 32'h1000,    0, 8'd2);
        vecs[6] = mk(1, 4'hF, 32'h0000_3004, 32'hABCD0000, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,  1, 1, 32'h0,        32'h3004,    1, 8'd3);
        vecs[7] = mk(0, 4'hF, 32'h0000_1010, 32'h0,        4, 0, 32'h0,        32'h5A5A5A5A, 2'b10, 32'h10, 5, 0, 32'h5A5A5A5A, 32'h3004,    1, 8'd3);
        vecs[8] = mk(1, 4'h1, 32'h0000_0000, 32'h000000EE, 0, 0, 32'h0,        32'h0,        2'b01, 32'h0,  5, 1, 32'h0,        32'h0,       1, 8'd4);

        rst_i = 1'b1; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = 4'h0; m_addr_i = 32'h0;
        m_wdata_i = 32'h0; s_rdata_i = 64'h0; s_ready_i = 2'b00; err_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset rvalid", 32'(m_rvalid_o), 32'd0);
        chk("reset s_req", 32'(s_req_o), 32'd0);
        chk("reset err_cnt", 32'(err_cnt_o), 32'd0);
        chk("reset s_addr", s_addr_o, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while the access to slave 0 is still waiting for ready.
        @(negedge clk_i);
        m_req_i = 1'b1; m_we_i = 1'b1; m_be_i = 4'hF; m_addr_i = 32'h0; m_wdata_i = 32'h5;
        s_ready_i = 2'b00;
        @(negedge clk_i);
        m_req_i = 1'b0;
        chk("rst pre s_req", 32'(s_req_o), 32'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst s_req", 32'(s_req_o), 32'd0);
        chk("rst rvalid", 32'(m_rvalid_o), 32'd0);
        chk("rst err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst err_we", 32'(err_we_o), 32'd0);
        chk("rst s_we", 32'(s_we_o), 32'd0);
        chk("rst s_wdata", s_wdata_o, 32'd0);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (m_rvalid_o) saw = 1'b1;
        end
        chk("rst no response", 32'(saw), 32'd0);
        v = mk(0, 4'hF, 32'h0, 32'h0, 1, 0, 32'h87654321, 32'h0, 2'b01, 32'h0, 2, 0, 32'h87654321, 32'h0, 0, 8'd0);
        run_vec(v, "post-rst read");

        for (int i = 0; i < 256; i++) begin
            v = mk(i[0], 4'hF, 32'h2000 + 32'(i * 4), 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 1, 1,
                   32'h0, 32'h2000 + 32'(i * 4), i[0], (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            run_vec(v, $sformatf("sat%0d", i));
        end

        @(negedge clk_i);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("clr err_cnt", 32'(err_cnt_o), 32'd0);
        chk("clr err_addr", err_addr_o, 32'd0);
        chk("clr err_we", 32'(err_we_o), 32'd0);

        v = mk(0, 4'hF, 32'h4000, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 1, 1, 32'h0, 32'h4000, 0, 8'd1);
        run_vec(v, "refault1");
        v = mk(0, 4'hF, 32'h4100, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 1, 1, 32'h0, 32'h4100, 0, 8'd2);
        run_vec(v, "refault2");
        v = mk(1, 4'hF, 32'h2F00, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 1, 1, 32'h0, 32'h2F00, 1, 8'd1);
        v.clr = 1'b1;
        run_vec(v, "clr+fault");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/miriscv_data_bus.md
Name: miriscv_data_bus

Overview:
- Parametrised data-bus interconnect between the core data port and N_SLAVES memory-mapped targets (RAM, peripherals).
- Successor to the single-region RAM valid decode. Adds:
  - multiple address windows
  - wait-state support through per-slave ready
  - a request/grant/response handshake to the core
  - a bus-fault capture path for unmapped accesses and slave timeouts
- One outstanding transaction at a time.

Parameters:
- N_SLAVES, 4, number of slave channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8). BE_W = DATA_W/8.
- SLAVE_BASE, {N_SLAVES{32'h0}}, packed N_SLAVES*ADDR_W. Base address of slave k is at bits [k*ADDR_W +: ADDR_W].
- SLAVE_MASK, {N_SLAVES{32'hFFFF_FF00}}, packed. Slave k hits when (addr & mask_k) == (base_k & mask_k).
- TIMEOUT, 16, max ACCESS cycles before a timeout fault (>=1).
- ERR_CNT_W, 8, width of the fault counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  1  core request
- m_we_i  in  1  core write enable
- m_be_i  in  BE_W  core byte enables
- m_addr_i  in  ADDR_W  core address
- m_wdata_i  in  DATA_W  core write data
- m_gnt_o  out  1  request accepted (1-cycle pulse)
- m_rvalid_o  out  1  response valid (1-cycle pulse)
- m_rdata_o  out  DATA_W  read data, valid with m_rvalid_o
- m_err_o  out  1  response is a bus fault, valid with m_rvalid_o
- s_req_o  out  N_SLAVES  per-slave request, one-hot or zero
- s_we_o  out  1  shared latched write enable
- s_be_o  out  BE_W  shared latched byte enables
- s_addr_o  out  ADDR_W  latched address minus base of the selected slave
- s_wdata_o  out  DATA_W  shared latched write data
- s_rdata_i  in  N_SLAVES*DATA_W  per-slave read data
- s_ready_i  in  N_SLAVES  per-slave completion
- err_addr_o  out  ADDR_W  address of the most recent fault
- err_we_o  out  1  we of the most recent fault
- err_cnt_o  out  ERR_CNT_W  saturating fault count
- err_clr_i  in  1  clears err_cnt_o, err_addr_o and err_we_o

Behaviour:
- FSM states: IDLE, ACCESS, RESP, ERROR. Reset (rst_i=1 at a clock edge) forces IDLE.
- Reset values: all outputs 0. Latched request fields, select and timeout counter all 0.
- Reset mid-transaction abandons the transaction; no response is issued.
- IDLE:
  - If m_req_i=1, pulse m_gnt_o the same cycle (combinational), latch we/be/addr/wdata, and decode.
  - Hit: latch sel = lowest hitting index (overlaps resolve to the lowest index), go to ACCESS.
  - No hit: go to ERROR with cause unmapped.
  - m_gnt_o is 0 in every other state; the core holds its request until granted.
- ACCESS:
  - s_req_o[sel]=1; all other bits 0. Shared fields are driven from the latches and stay stable for the whole state.
  - s_ready_i[sel]=1: capture s_rdata_i[sel] (zero on writes), go to RESP.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 with no ready, go to ERROR with cause timeout.
  - Ready and timeout in the same cycle: ready wins.
  - Ready bits of unselected slaves are ignored.
- RESP: m_rvalid_o=1, m_err_o=0, m_rdata_o=captured data. Next state IDLE.
- ERROR: m_rvalid_o=1, m_err_o=1, m_rdata_o=0. Next state IDLE.
- Fault capture, on entry to ERROR: err_addr_o <= latched addr, err_we_o <= latched we, err_cnt_o increments and saturates at all-ones.
- err_clr_i clears the fault registers. If err_clr_i coincides with a fault entry, the new fault is recorded: err_cnt=1 and the address is updated.
- Latency: minimum 2 cycles from grant to rvalid with a zero-wait slave (grant at T, ACCESS at T+1 with ready, rvalid at T+2). Each wait state adds 1 cycle.
- Unmapped access: rvalid 1 cycle after grant.
- Timeout: rvalid TIMEOUT+1 cycles after grant.
- Throughput: a new grant is possible in the cycle after rvalid.
- m_rdata_o, m_err_o and m_rvalid_o are registered; all three are 0 outside RESP/ERROR.

Test Plan:
- Setup: N_SLAVES=2, base0=0x0 mask0=0xFFFFFF00, base1=0x1000 mask1=0xFFFFF000, TIMEOUT=4.
- Read 0x40, slave0 ready immediately with rdata 0xDEADBEEF -> gnt at T, s_req_o=2'b01 and s_addr_o=0x40 at T+1, rvalid with rdata 0xDEADBEEF and err=0 at T+2.
- Write 0x1008 wdata 0x12345678 be=4'b0011, slave1 ready after 3 wait cycles -> s_req_o=2'b10 held 4 cycles with s_addr_o=0x008 and stable wdata/be; rvalid err=0 at T+5.
- Read 0x2000 (unmapped) -> rvalid err=1 rdata=0 at T+1; err_addr_o=0x2000, err_we_o=0, err_cnt_o=1.
- Read 0x1000 with slave1 never ready -> s_req_o held exactly 4 cycles, err=1 at T+5, err_cnt_o=2. Then assert err_clr_i -> err_cnt_o=0 and err_addr_o=0.
- rst_i asserted while in ACCESS -> next cycle all outputs 0, no rvalid. A following read of 0x0 completes normally in 2 cycles.
- 256 unmapped accesses with ERR_CNT_W=8 -> err_cnt_o saturates at 255. Additionally, err_clr_i on the cycle of a fault entry -> err_cnt_o=1.
